// File: rtl/calc_envelope_level.sv
// Per-operator ADSR envelope generator: 36-entry level/phase state, read at p0, updated at p2, level out at p3.
// Optional build macro OPL3_EG_STATE_OUT_EN adds the env_phase_p3 output.
module calc_envelope_level #(
  parameter int NUM_BANKS       = 2,
  parameter int OPS_PER_BANK    = 18,
  parameter int ENV_LVL_WIDTH   = 9,
  parameter int EG_OFF_THRESH   = 32'h1F8,
  parameter int REG_ENV_WIDTH   = 4,
  parameter int ENV_SHIFT_WIDTH = 4,
  parameter int BANK_NUM_WIDTH  = 1,
  parameter int OP_NUM_WIDTH    = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_clk_en,
  input  logic [BANK_NUM_WIDTH-1:0]  bank_num,
  input  logic [OP_NUM_WIDTH-1:0]    op_num,
  input  logic                       key_on,
  input  logic [REG_ENV_WIDTH-1:0]   ar,
  input  logic [REG_ENV_WIDTH-1:0]   dr,
  input  logic [REG_ENV_WIDTH-1:0]   rr,
  input  logic [REG_ENV_WIDTH-1:0]   sl,
  input  logic                       egt,
  output logic [REG_ENV_WIDTH-1:0]   requested_rate_p0,
  input  logic [REG_ENV_WIDTH-1:0]   rate_hi_p2,
  input  logic [ENV_SHIFT_WIDTH-1:0] env_shift_p2,
  output logic [ENV_LVL_WIDTH-1:0]   env_level_p3,
`ifdef OPL3_EG_STATE_OUT_EN
  output logic [1:0]                 env_phase_p3,
`endif
  output logic                       sample_clk_en_p3
);

  localparam int DEPTH = NUM_BANKS * OPS_PER_BANK;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = ENV_LVL_WIDTH + 4;
  localparam logic [ENV_LVL_WIDTH-1:0] LVL_MAX  = {ENV_LVL_WIDTH{1'b1}};
  localparam logic [ENV_LVL_WIDTH-1:0] LVL_ZERO = {ENV_LVL_WIDTH{1'b0}};
  localparam logic [ENV_LVL_WIDTH-1:0] OFF_LVL  = ENV_LVL_WIDTH'(EG_OFF_THRESH);
  localparam logic [REG_ENV_WIDTH-1:0] RATE_MAX = {REG_ENV_WIDTH{1'b1}};

  typedef enum logic [1:0] {ATTACK = 2'd0, DECAY = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} phase_t;

  typedef struct packed {
    logic                      valid;
    logic                      in_range;
    logic [IDX_W-1:0]          idx;
    logic [ENV_LVL_WIDTH-1:0]  level;
    phase_t                    phase;
    logic                      key_on;
    logic [REG_ENV_WIDTH-1:0]  sl;
  } slot_t;

  logic [ENV_LVL_WIDTH-1:0] level_q [DEPTH];
  phase_t                   phase_q [DEPTH];

  slot_t                    p1_d, p1_q, p2_q;
  logic                     in_range_s;
  logic [IDX_W-1:0]         idx_s;
  logic                     restart_s, off_s, wr_en_s;
  logic [4:0]               slx_s;
  logic [ENV_LVL_WIDTH-1:0] lvl_base_s, inc_s, dec_inc_s, level_nxt_s;
  logic signed [AW-1:0]     atk_base_s, atk_shl_s, atk_inc_s;
  phase_t                   phase_nxt_s;
  logic [ENV_LVL_WIDTH-1:0] env_level_d, env_level_q;
  logic                     sample_en_d, sample_en_q;
`ifdef OPL3_EG_STATE_OUT_EN
  logic [1:0]               env_phase_d, env_phase_q;
`endif

  // p0: locate the slot, read its state and pick the rate for the shift block
  always_comb begin
    in_range_s = (int'(op_num) < OPS_PER_BANK) && (int'(bank_num) < NUM_BANKS);
    idx_s      = in_range_s ? IDX_W'(int'(bank_num) * OPS_PER_BANK + int'(op_num)) : {IDX_W{1'b0}};
    p1_d.valid    = sample_clk_en;
    p1_d.in_range = in_range_s;
    p1_d.idx      = idx_s;
    p1_d.level    = level_q[idx_s];
    p1_d.phase    = phase_q[idx_s];
    p1_d.key_on   = key_on;
    p1_d.sl       = sl;
    case (phase_q[idx_s])
      ATTACK:  requested_rate_p0 = ar;
      DECAY:   requested_rate_p0 = dr;
      SUSTAIN: requested_rate_p0 = egt ? {REG_ENV_WIDTH{1'b0}} : rr;
      RELEASE: requested_rate_p0 = key_on ? ar : rr;
      default: requested_rate_p0 = rr;
    endcase
  end

  // p2: next level/phase for the slot, plus the p3 output values
  always_comb begin
    restart_s = p2_q.key_on && (p2_q.phase == RELEASE);
    off_s     = p2_q.level >= OFF_LVL;
    slx_s     = (p2_q.sl == RATE_MAX) ? 5'd31 : 5'(p2_q.sl);
    if (restart_s && (rate_hi_p2 == RATE_MAX)) begin
      lvl_base_s = LVL_ZERO;
    end else if (off_s && !restart_s && (p2_q.phase != ATTACK)) begin
      lvl_base_s = LVL_MAX;
    end else begin
      lvl_base_s = p2_q.level;
    end
    // ~level == -level-1; the arithmetic shifts keep the step negative so attack falls toward 0
    atk_base_s = ~$signed(AW'(p2_q.level));
    atk_shl_s  = atk_base_s <<< env_shift_p2;
    atk_inc_s  = atk_shl_s >>> 4'd4;
    if (!off_s && !restart_s && (env_shift_p2 != {ENV_SHIFT_WIDTH{1'b0}})) begin
      dec_inc_s = ENV_LVL_WIDTH'(1) << (env_shift_p2 - ENV_SHIFT_WIDTH'(1));
    end else begin
      dec_inc_s = LVL_ZERO;
    end
    inc_s       = LVL_ZERO;
    phase_nxt_s = p2_q.phase;
    case (p2_q.phase)
      ATTACK: begin
        if (p2_q.level == LVL_ZERO) begin
          phase_nxt_s = DECAY;
        end else if (p2_q.key_on && (env_shift_p2 != {ENV_SHIFT_WIDTH{1'b0}}) && (rate_hi_p2 != RATE_MAX)) begin
          inc_s = ENV_LVL_WIDTH'(atk_inc_s);
        end else begin
          inc_s = LVL_ZERO;
        end
      end
      DECAY: begin
        if (p2_q.level[ENV_LVL_WIDTH-1 -: 5] == slx_s) begin
          phase_nxt_s = SUSTAIN;
        end else begin
          inc_s = dec_inc_s;
        end
      end
      SUSTAIN: inc_s = dec_inc_s;
      RELEASE: inc_s = dec_inc_s;
      default: inc_s = LVL_ZERO;
    endcase
    level_nxt_s = lvl_base_s + inc_s;
    if (!p2_q.key_on) begin
      phase_nxt_s = RELEASE;
    end else if (restart_s) begin
      phase_nxt_s = ATTACK;
    end else begin
      phase_nxt_s = phase_nxt_s;
    end
    wr_en_s     = p2_q.valid && p2_q.in_range;
    sample_en_d = p2_q.valid;
    if (p2_q.valid) begin
      env_level_d = p2_q.in_range ? level_nxt_s : LVL_MAX;
    end else begin
      env_level_d = env_level_q;
    end
`ifdef OPL3_EG_STATE_OUT_EN
    if (p2_q.valid) begin
      env_phase_d = p2_q.in_range ? phase_nxt_s : RELEASE;
    end else begin
      env_phase_d = env_phase_q;
    end
`endif
  end

  // Pipeline stages and registered outputs; reset drops any in-flight slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q        <= '0;
      p2_q        <= '0;
      env_level_q <= LVL_MAX;
      sample_en_q <= 1'b0;
`ifdef OPL3_EG_STATE_OUT_EN
      env_phase_q <= RELEASE;
`endif
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p1_q;
      env_level_q <= env_level_d;
      sample_en_q <= sample_en_d;
`ifdef OPL3_EG_STATE_OUT_EN
      env_phase_q <= env_phase_d;
`endif
    end
  end

  // Per-operator state, written back at p2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        level_q[i] <= LVL_MAX;
        phase_q[i] <= RELEASE;
      end
    end else if (wr_en_s) begin
      level_q[p2_q.idx] <= level_nxt_s;
      phase_q[p2_q.idx] <= phase_nxt_s;
    end
  end

  assign env_level_p3     = env_level_q;
  assign sample_clk_en_p3 = sample_en_q;
`ifdef OPL3_EG_STATE_OUT_EN
  assign env_phase_p3     = env_phase_q;
`endif

endmodule

// File: tb/tb_calc_envelope_level.sv
// Directed bench for calc_envelope_level: one slot in flight at a time, checked at p0 and p3.
module tb_calc_envelope_level;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_clk_en;
  logic [0:0] bank_num;
  logic [4:0] op_num;
  logic       key_on;
  logic [3:0] ar, dr, rr, sl;
  logic       egt;
  logic [3:0] requested_rate_p0;
  logic [3:0] rate_hi_p2;
  logic [3:0] env_shift_p2;
  logic [8:0] env_level_p3;
  logic       sample_clk_en_p3;
`ifdef OPL3_EG_STATE_OUT_EN
  logic [1:0] env_phase_p3;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] rq;
  logic [8:0] lv;
  logic       e3;
  logic [1:0] ph;
  logic [8:0] atk_tab [9] = '{9'h0FF, 9'h07F, 9'h03F, 9'h01F, 9'h00F, 9'h007, 9'h003, 9'h001, 9'h000};

  always #5 clk = ~clk;

  calc_envelope_level dut (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
    .bank_num(bank_num), .op_num(op_num), .key_on(key_on),
    .ar(ar), .dr(dr), .rr(rr), .sl(sl), .egt(egt),
    .requested_rate_p0(requested_rate_p0),
    .rate_hi_p2(rate_hi_p2), .env_shift_p2(env_shift_p2),
    .env_level_p3(env_level_p3),
`ifdef OPL3_EG_STATE_OUT_EN
    .env_phase_p3(env_phase_p3),
`endif
    .sample_clk_en_p3(sample_clk_en_p3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic [0:0] bk, input logic [4:0] op, input logic kon,
                          input logic [3:0] a, input logic [3:0] d, input logic [3:0] r,
                          input logic [3:0] s, input logic e, input logic [3:0] rh,
                          input logic [3:0] sh, input logic vld);
    bank_num = bk; op_num = op; key_on = kon;
    ar = a; dr = d; rr = r; sl = s; egt = e;
    rate_hi_p2 = rh; env_shift_p2 = sh; sample_clk_en = vld;
  endtask

  // One slot: p0 rate sampled after drive, level/valid sampled just after the p3 edge
  task automatic run_slot(input logic [0:0] bk, input logic [4:0] op, input logic kon,
                          input logic [3:0] a, input logic [3:0] d, input logic [3:0] r,
                          input logic [3:0] s, input logic e, input logic [3:0] rh,
                          input logic [3:0] sh, input logic vld,
                          output logic [3:0] req, output logic [8:0] lvl, output logic en3,
                          output logic [1:0] phs);
    @(negedge clk);
    drive_p0(bk, op, kon, a, d, r, s, e, rh, sh, vld);
    #1 req = requested_rate_p0;
    @(posedge clk);
    @(negedge clk);
    sample_clk_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 lvl = env_level_p3;
    en3 = sample_clk_en_p3;
`ifdef OPL3_EG_STATE_OUT_EN
    phs = env_phase_p3;
`else
    phs = 2'd0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive_p0(1'b0, 5'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("reset_level", 32'(env_level_p3), 32'h1FF);
    chk("reset_en3", 32'(sample_clk_en_p3), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // 1: key-off slot after reset
    run_slot(1'b0, 5'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("t1_rate", 32'(rq), 32'd3);
    chk("t1_level", 32'(lv), 32'h1FF);
    chk("t1_en3", 32'(e3), 32'd1);
`ifdef OPL3_EG_STATE_OUT_EN
    chk("t1_phase", 32'(ph), 32'd3);
`endif

    // 2: instant attack at rate 15, then ATTACK->DECAY
    run_slot(1'b1, 5'd5, 1'b1, 4'd15, 4'd6, 4'd7, 4'd2, 1'b0, 4'd15, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("t2_rate_restart", 32'(rq), 32'd15);
    chk("t2_level0", 32'(lv), 32'h0);
    run_slot(1'b1, 5'd5, 1'b1, 4'd15, 4'd6, 4'd7, 4'd2, 1'b0, 4'd15, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("t2_rate_atk", 32'(rq), 32'd15);
    chk("t2_level_hold", 32'(lv), 32'h0);
`ifdef OPL3_EG_STATE_OUT_EN
    chk("t2_phase_dec", 32'(ph), 32'd1);
`endif
    run_slot(1'b1, 5'd5, 1'b1, 4'd15, 4'd6, 4'd7, 4'd2, 1'b0, 4'd6, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("t2_rate_dec", 32'(rq), 32'd6);
    chk("t2_level_dec", 32'(lv), 32'h0);

    // out-of-range op: forced silent output, no state write (op 20 would alias bank1 op2)
    run_slot(1'b0, 5'd20, 1'b1, 4'd15, 4'd6, 4'd7, 4'd2, 1'b0, 4'd15, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("oor_level", 32'(lv), 32'h1FF);
    chk("oor_en3", 32'(e3), 32'd1);
    run_slot(1'b1, 5'd2, 1'b0, 4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("oor_alias_level", 32'(lv), 32'h1FF);

    // 3: attack curve on op(0,1), rate_hi=10 shift=3
    run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1, rq, lv, e3, ph);
    chk("t3_rate_restart", 32'(rq), 32'd10);
    chk("t3_level_restart", 32'(lv), 32'h1FF);
    for (int k = 0; k < 9; k++) begin
      run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1, rq, lv, e3, ph);
      chk($sformatf("t3_atk_%0d", k), 32'(lv), 32'(atk_tab[k]));
    end
    chk("t3_rate_atk", 32'(rq), 32'd10);
    run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1, rq, lv, e3, ph);
    chk("t3_level_to_dec", 32'(lv), 32'h0);
`ifdef OPL3_EG_STATE_OUT_EN
    chk("t3_phase_dec", 32'(ph), 32'd1);
`endif

    // 4: decay +2 per slot to level 32, then sustain; egt holds level
    for (int k = 1; k <= 16; k++) begin
      run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd5, 4'd2, 1'b1, rq, lv, e3, ph);
      chk($sformatf("t4_dec_%0d", k), 32'(lv), 32'(2 * k));
    end
    chk("t4_rate_dec", 32'(rq), 32'd5);
    run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd5, 4'd2, 1'b1, rq, lv, e3, ph);
    chk("t4_level_to_sus", 32'(lv), 32'd32);
`ifdef OPL3_EG_STATE_OUT_EN
    chk("t4_phase_sus", 32'(ph), 32'd2);
`endif
    for (int k = 0; k < 2; k++) begin
      run_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd5, 4'd7, 4'd2, 1'b1, 4'd0, 4'd0, 1'b1, rq, lv, e3, ph);
      chk($sformatf("t4_egt_rate_%0d", k), 32'(rq), 32'd0);
      chk($sformatf("t4_egt_level_%0d", k), 32'(lv), 32'd32);
    end

    // invalid slot leaves output and state untouched
    run_slot(1'b0, 5'd1, 1'b0, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd7, 4'd4, 1'b0, rq, lv, e3, ph);
    chk("idle_level", 32'(lv), 32'd32);
    chk("idle_en3", 32'(e3), 32'd0);

    // 5: key-off in sustain, release +8 per slot to 0x1F8, then forced to 0x1FF
    for (int k = 1; k <= 59; k++) begin
      run_slot(1'b0, 5'd1, 1'b0, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd7, 4'd4, 1'b1, rq, lv, e3, ph);
      chk($sformatf("t5_rel_%0d", k), 32'(lv), 32'(32 + 8 * k));
      if (k <= 2) chk($sformatf("t5_rate_%0d", k), 32'(rq), 32'd7);
    end
`ifdef OPL3_EG_STATE_OUT_EN
    chk("t5_phase_rel", 32'(ph), 32'd3);
`endif
    for (int k = 0; k < 2; k++) begin
      run_slot(1'b0, 5'd1, 1'b0, 4'd10, 4'd5, 4'd7, 4'd2, 1'b0, 4'd7, 4'd4, 1'b1, rq, lv, e3, ph);
      chk($sformatf("t5_off_%0d", k), 32'(lv), 32'h1FF);
    end

    // 6: reset during an attack on op(0,3)
    run_slot(1'b0, 5'd3, 1'b1, 4'd10, 4'd5, 4'd3, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1, rq, lv, e3, ph);
    run_slot(1'b0, 5'd3, 1'b1, 4'd10, 4'd5, 4'd3, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1, rq, lv, e3, ph);
    chk("t6_pre_level", 32'(lv), 32'h0FF);
    @(negedge clk);
    drive_p0(1'b0, 5'd3, 1'b1, 4'd10, 4'd5, 4'd3, 4'd2, 1'b0, 4'd10, 4'd3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    sample_clk_en = 1'b0;
    reset_n = 1'b0;
    #1 chk("t6_rst_level", 32'(env_level_p3), 32'h1FF);
    chk("t6_rst_en3", 32'(sample_clk_en_p3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t6_flush_en3", 32'(sample_clk_en_p3), 32'd0);
    chk("t6_flush_level", 32'(env_level_p3), 32'h1FF);
    run_slot(1'b0, 5'd3, 1'b0, 4'd10, 4'd5, 4'd3, 4'd2, 1'b0, 4'd0, 4'd0, 1'b1, rq, lv, e3, ph);
    chk("t6_post_rate", 32'(rq), 32'd3);
    chk("t6_post_level", 32'(lv), 32'h1FF);
    chk("t6_post_en3", 32'(e3), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
